qeciphy_crc8_arbiter: RTL and testbench

- Shares one single-byte CRC-8/SMBUS engine between `NUM_REQ` independent requesters, e.g. TX frame builder and RX frame checker.
- Grants the engine round-robin and registers each result into a one-entry response buffer.
- Returns the result to the owning requester over a valid/ready handshake.
- Removes the need for one CRC engine per lane-side consumer.

---
 rtl/qeciphy_pkg.sv | 27 ++
 rtl/qeciphy_crc8_arbiter_if.sv | 22 ++
 rtl/qeciphy_crc8_smbus.sv | 12 +
 rtl/qeciphy_crc8_arbiter.sv | 102 ++++++++++
 tb/tb_qeciphy_crc8_arbiter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/qeciphy_pkg.sv
// Shared constants, buffer-state type and the bytewise CRC-8/SMBUS helper
// used by the qeciphy CRC arbiter slice.
package qeciphy_pkg;

   localparam logic [7:0] CRC8_SMBUS_POLY = 8'h07;
   localparam logic [7:0] CRC8_SMBUS_INIT = 8'h00;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_e;

   // MSB-first CRC update of one byte, no reflection and no final xor.
   function automatic logic [7:0] crc8_smbus_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int b = 0; b < 8; b++) begin
         if (c[7]) begin
            c = {c[6:0], 1'b0} ^ CRC8_SMBUS_POLY;
         end else begin
            c = {c[6:0], 1'b0};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/qeciphy_crc8_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared CRC arbiter.
interface qeciphy_crc8_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [7:0]           rsp_crc;
   logic [NUM_REQ-1:0]   rsp_ready;
   logic                 busy;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_crc, busy
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_crc, busy
   );
endinterface

// File: rtl/qeciphy_crc8_smbus.sv
// Single-byte CRC-8/SMBUS engine; each byte is computed from the fixed init value.
module qeciphy_crc8_smbus
   import qeciphy_pkg::*;
(
   input  logic       valid_i,
   input  logic [7:0] data_i,
   output logic [7:0] crc_o
);

   assign crc_o = valid_i ? crc8_smbus_byte(CRC8_SMBUS_INIT, data_i) : CRC8_SMBUS_INIT;

endmodule

// File: rtl/qeciphy_crc8_arbiter.sv
// Round-robin arbiter sharing one CRC-8/SMBUS engine between NUM_REQ requesters,
// with a one-entry response buffer returned to the owning requester.
module qeciphy_crc8_arbiter
   import qeciphy_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   qeciphy_crc8_arbiter_if.slave     bus
);

   localparam int PTR_W = $clog2(NUM_REQ);
   typedef logic [PTR_W-1:0] idx_t;

   buf_state_e         state_q, state_d;
   idx_t               ptr_q, ptr_d;
   idx_t               owner_q, owner_d;
   logic [7:0]         crc_q, crc_d;

   logic [PTR_W:0]     pick_s;
   idx_t               grant_idx_s;
   logic               grant_vld_s;
   logic               drain_s;
   logic               accept_s;
   logic [7:0]         mux_byte_s;
   logic [7:0]         engine_crc_s;
   logic [NUM_REQ-1:0] req_ready_s;

   // Scan downward so the last hit written is the first valid at or after ptr.
   function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] valid, input idx_t ptr);
      logic [PTR_W:0] res;
      int             idx;
      res = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (valid[idx]) begin
            res = {1'b1, idx_t'(idx)};
         end
      end
      return res;
   endfunction

   qeciphy_crc8_smbus u_crc (
      .valid_i (1'b1),
      .data_i  (mux_byte_s),
      .crc_o   (engine_crc_s)
   );

   always_comb begin
      pick_s      = rr_pick(bus.req_valid, ptr_q);
      grant_idx_s = pick_s[PTR_W-1:0];
      grant_vld_s = pick_s[PTR_W];
      mux_byte_s  = bus.req_data[int'(grant_idx_s)*8 +: 8];
      // A drain frees the buffer in the same cycle, which is what allows back-to-back accepts.
      drain_s     = (state_q == FULL) && bus.rsp_ready[owner_q];
      accept_s    = grant_vld_s && ((state_q == EMPTY) || drain_s) && !rst_i;
      req_ready_s = '0;
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      crc_d       = crc_q;
      if (accept_s) begin
         req_ready_s[grant_idx_s] = 1'b1;
         state_d = FULL;
         owner_d = grant_idx_s;
         crc_d   = engine_crc_s;
         if (grant_idx_s == idx_t'(NUM_REQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grant_idx_s + idx_t'(1);
         end
      end else if (drain_s) begin
         state_d = EMPTY;
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         owner_q <= '0;
         crc_q   <= CRC8_SMBUS_INIT;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         crc_q   <= crc_d;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = (state_q == FULL) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
   assign bus.rsp_crc   = crc_q;
   assign bus.busy      = (state_q == FULL);

endmodule

// File: tb/tb_qeciphy_crc8_arbiter.sv
// Directed bench for the shared CRC-8/SMBUS arbiter: a 2-requester and a
// 4-requester instance driven by one linear sequence of steps.
module tb_qeciphy_crc8_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   qeciphy_crc8_arbiter_if #(.NUM_REQ(2)) bus2 ();
   qeciphy_crc8_arbiter_if #(.NUM_REQ(4)) bus4 ();

   qeciphy_crc8_arbiter #(.NUM_REQ(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2.slave));
   qeciphy_crc8_arbiter #(.NUM_REQ(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus2.req_valid = 2'b11;
      bus2.req_data  = {8'hFF, 8'h01};
      bus2.rsp_ready = 2'b00;
      bus4.req_valid = 4'b0000;
      bus4.req_data  = 32'h0;
      bus4.rsp_ready = 4'b1111;

      // Reset held three cycles with both requesters valid
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_req_ready", 32'(bus2.req_ready), 32'h0);
         chk("rst_rsp_valid", 32'(bus2.rsp_valid), 32'h0);
         chk("rst_rsp_crc", 32'(bus2.rsp_crc), 32'h00);
         chk("rst_busy", 32'(bus2.busy), 32'h0);
      end
      rst = 1'b0;
      #1;
      chk("first_grant_r0", 32'(bus2.req_ready), 32'h1);

      // Requester 0 sends 0x01
      tick();
      bus2.req_valid = 2'b10;
      bus2.rsp_ready = 2'b00;
      #1;
      chk("single0_rsp_valid", 32'(bus2.rsp_valid), 32'h1);
      chk("single0_crc", 32'(bus2.rsp_crc), 32'h07);
      chk("single0_busy", 32'(bus2.busy), 32'h1);
      chk("full_stall_ready", 32'(bus2.req_ready), 32'h0);

      // Drain r0 and accept r1 (0xFF) in the same cycle
      bus2.rsp_ready = 2'b01;
      #1;
      chk("b2b_ready_r1", 32'(bus2.req_ready), 32'h2);
      tick();
      bus2.req_valid = 2'b00;
      bus2.rsp_ready = 2'b00;
      #1;
      chk("single1_rsp_valid", 32'(bus2.rsp_valid), 32'h2);
      chk("single1_crc", 32'(bus2.rsp_crc), 32'hF3);
      bus2.rsp_ready = 2'b10;
      tick();
      chk("drain1_rsp_valid", 32'(bus2.rsp_valid), 32'h0);
      chk("drain1_busy", 32'(bus2.busy), 32'h0);
      chk("drain1_crc_hold", 32'(bus2.rsp_crc), 32'hF3);

      // Contention: both valid, responses taken every cycle
      bus2.req_data  = {8'h00, 8'h80};
      bus2.req_valid = 2'b11;
      bus2.rsp_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("cont_ready", 32'(bus2.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
         tick();
         chk("cont_rsp_valid", 32'(bus2.rsp_valid), (i % 2 == 0) ? 32'h1 : 32'h2);
         chk("cont_crc", 32'(bus2.rsp_crc), (i % 2 == 0) ? 32'h89 : 32'h00);
      end
      bus2.req_valid = 2'b00;
      tick();
      chk("cont_drain", 32'(bus2.rsp_valid), 32'h0);

      // Back-pressure on requester 0's response for 5 cycles
      bus2.req_data  = {8'h00, 8'h01};
      bus2.req_valid = 2'b01;
      bus2.rsp_ready = 2'b00;
      tick();
      bus2.req_data = {8'h00, 8'hFF};
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_crc", 32'(bus2.rsp_crc), 32'h07);
         chk("bp_ready", 32'(bus2.req_ready), 32'h0);
         chk("bp_busy", 32'(bus2.busy), 32'h1);
         tick();
      end
      chk("bp_rsp_valid", 32'(bus2.rsp_valid), 32'h1);
      bus2.rsp_ready = 2'b01;
      #1;
      chk("bp_release_ready", 32'(bus2.req_ready), 32'h1);
      tick();
      bus2.req_valid = 2'b00;
      #1;
      chk("bp_next_valid", 32'(bus2.rsp_valid), 32'h1);
      chk("bp_next_crc", 32'(bus2.rsp_crc), 32'hF3);
      tick();
      chk("bp_drain", 32'(bus2.busy), 32'h0);

      // Reset while FULL discards the response
      bus2.req_data  = {8'h80, 8'h00};
      bus2.req_valid = 2'b10;
      bus2.rsp_ready = 2'b00;
      tick();
      bus2.req_valid = 2'b00;
      chk("mid_full_crc", 32'(bus2.rsp_crc), 32'h89);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rsp_valid", 32'(bus2.rsp_valid), 32'h0);
      chk("mid_crc", 32'(bus2.rsp_crc), 32'h00);
      chk("mid_busy", 32'(bus2.busy), 32'h0);
      bus2.rsp_ready = 2'b11;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("mid_no_ghost", 32'(bus2.rsp_valid), 32'h0);
      end

      // Four requesters: move ptr to 3, then check wrap-around order
      bus4.req_data  = {8'hFF, 8'h00, 8'h01, 8'h01};
      bus4.req_valid = 4'b0100;
      tick();
      chk("w4_r2_valid", 32'(bus4.rsp_valid), 32'h4);
      bus4.req_valid = 4'b1001;
      #1;
      chk("w4_ready_r3", 32'(bus4.req_ready), 32'h8);
      tick();
      chk("w4_rsp_r3", 32'(bus4.rsp_valid), 32'h8);
      chk("w4_crc_r3", 32'(bus4.rsp_crc), 32'hF3);
      bus4.req_valid = 4'b0001;
      #1;
      chk("w4_ready_r0", 32'(bus4.req_ready), 32'h1);
      tick();
      bus4.req_valid = 4'b0000;
      #1;
      chk("w4_rsp_r0", 32'(bus4.rsp_valid), 32'h1);
      chk("w4_crc_r0", 32'(bus4.rsp_crc), 32'h07);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
